// File: rtl/aim65_ram_arbiter.sv
// aim65_ram_arbiter
// Shares the single-port synchronous main RAM between the 6502 CPU and a host
// loader/debug port. The CPU has priority; the host uses idle RAM cycles or
// steals one CPU read cycle (via RDY) once it has deferred MAX_WAIT cycles.
// Optional CPU write protection at and above PROT_BASE is built in when the
// macro AIM65_ARB_WRPROT_EN is defined.

module aim65_ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 15
`ifdef AIM65_ARB_WRPROT_EN
  ,
  parameter logic [ADDR_WIDTH-1:0] PROT_BASE = 15'h7000
`endif
) (
  input  logic                  cpu_clk,
  input  logic                  reset,
  input  logic                  cpu_ram_cs,
  input  logic                  cpu_rw,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_dout,
  output logic                  cpu_rdy,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_busy,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  ram_cs,
  output logic                  ram_rw,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  prot_viol
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [CW-1:0]           wait_cnt;
  logic                    h_we;
  logic [ADDR_WIDTH-1:0]   h_addr;
  logic [DATA_WIDTH-1:0]   h_wdata;
  logic                    slot;
  logic                    grant;
  logic                    accept;
  logic                    cpu_wr_blocked;

`ifdef AIM65_ARB_WRPROT_EN
  assign cpu_wr_blocked = cpu_ram_cs & ~cpu_rw & (cpu_addr >= PROT_BASE);

  // Flag a suppressed CPU write one cycle after it was attempted
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      prot_viol <= 1'b0;
    end else begin
      prot_viol <= cpu_wr_blocked;
    end
  end
`else
  assign cpu_wr_blocked = 1'b0;
  assign prot_viol      = 1'b0;
`endif

  // Arbitration state register
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state; a request seen while the previous ack is still up is that same request, so it is ignored
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    accept   = 1'b0;
    slot     = ~cpu_ram_cs | ((wait_cnt == WAIT_MAX) & cpu_rw);
    case (state)
      IDLE: begin
        if (host_req & ~host_ack) begin
          accept   = 1'b1;
          state_nx = PEND;
        end
      end
      PEND: begin
        if (slot) begin
          grant    = 1'b1;
          state_nx = CAPT;
        end
      end
      CAPT: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Latch the host transaction, count deferrals and return read data with the ack
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      wait_cnt   <= '0;
      h_we       <= 1'b0;
      h_addr     <= '0;
      h_wdata    <= '0;
      host_busy  <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_ack <= 1'b0;
      if (accept) begin
        h_we      <= host_we;
        h_addr    <= host_addr;
        h_wdata   <= host_wdata;
        wait_cnt  <= '0;
        host_busy <= 1'b1;
      end
      if ((state == PEND) && !slot && (wait_cnt != WAIT_MAX)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == CAPT) begin
        host_ack  <= 1'b1;
        host_busy <= 1'b0;
        if (!h_we) begin
          host_rdata <= ram_dout;
        end
      end
    end
  end

  // RAM port mux: CPU by default, host only in its grant cycle; a grant during CPU traffic stalls the CPU
  always_comb begin
    ram_cs   = cpu_ram_cs & ~cpu_wr_blocked;
    ram_rw   = cpu_rw;
    ram_addr = cpu_addr;
    ram_din  = cpu_dout;
    cpu_rdy  = 1'b1;
    if (grant) begin
      ram_cs   = 1'b1;
      ram_rw   = ~h_we;
      ram_addr = h_addr;
      ram_din  = h_wdata;
      cpu_rdy  = ~cpu_ram_cs;
    end
    if (reset) begin
      ram_cs = 1'b0;
    end
  end

endmodule

// File: tb/tb_aim65_ram_arbiter.sv
// tb_aim65_ram_arbiter
// Drives the arbiter with directed and random CPU/host traffic against a
// synchronous RAM model. Expectations come from a timeline model: it records
// the cycle a host request is accepted, predicts the grant cycle from the CPU
// traffic seen since then, and keeps a shadow copy of memory contents.
// Define AIM65_ARB_WRPROT_EN to also exercise write protection.

module tb_aim65_ram_arbiter;

  localparam int AW       = 15;
  localparam int DW       = 8;
  localparam int MAX_WAIT = 15;
  localparam int NEVER    = 1 << 30;
`ifdef AIM65_ARB_WRPROT_EN
  localparam logic [AW-1:0] PROT_BASE = 15'h7000;
`endif

  logic          cpu_clk = 1'b0;
  logic          reset;
  logic          cpu_ram_cs;
  logic          cpu_rw;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_dout;
  logic          cpu_rdy;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_busy;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          ram_cs;
  logic          ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          prot_viol;

  logic [DW-1:0] mem    [0:32767];
  logic [DW-1:0] shadow [0:32767];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Timeline model of the host transaction
  int            t_accept  = -100;
  int            t_ack     = -100;
  bit            m_granted = 1'b1;
  int            n_traffic = 0;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rd_cap;
  logic [DW-1:0] exp_rdata = '0;
  bit            prev_blocked = 1'b0;
  bit            prev_rd      = 1'b0;
  logic [DW-1:0] prev_rd_exp;
  bit            last_exp_rdy = 1'b1;

  always #5 cpu_clk = ~cpu_clk;

  aim65_ram_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_WAIT   (MAX_WAIT)
  ) dut (
    .cpu_clk    (cpu_clk),
    .reset      (reset),
    .cpu_ram_cs (cpu_ram_cs),
    .cpu_rw     (cpu_rw),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_rdy    (cpu_rdy),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_busy  (host_busy),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .ram_cs     (ram_cs),
    .ram_rw     (ram_rw),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .prot_viol  (prot_viol)
  );

  // Single-port synchronous RAM, one cycle read latency
  always @(posedge cpu_clk) begin
    if (ram_cs) begin
      if (!ram_rw) mem[ram_addr] <= ram_din;
      else         ram_dout      <= mem[ram_addr];
    end
  end

  // Bound on total run time
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit is_blocked(input bit cs, input bit rw, input logic [AW-1:0] addr);
`ifdef AIM65_ARB_WRPROT_EN
    return cs && !rw && (addr >= PROT_BASE);
`else
    return 1'b0 & cs & rw & (addr == '0);
`endif
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 32767));
    return 15'h6FF8 + AW'($urandom_range(0, 15));
  endfunction

  task automatic model_reset();
    t_accept     = -100;
    t_ack        = -100;
    m_granted    = 1'b1;
    n_traffic    = 0;
    exp_rdata    = '0;
    prev_blocked = 1'b0;
    prev_rd      = 1'b0;
    last_exp_rdy = 1'b1;
  endtask

  // One clock cycle: drive inputs after the edge, check at the falling edge, advance the model
  task automatic applyStimulus(input bit cs, input bit rw, input logic [AW-1:0] addr,
                               input logic [DW-1:0] dout, input bit hreq, input bit hwe,
                               input logic [AW-1:0] haddr, input logic [DW-1:0] hwdata);
    bit pend, grant, blk, exp_cs, exp_rdy, exp_busy;
    @(posedge cpu_clk);
    #1;
    cyc++;
    cpu_ram_cs = cs;
    cpu_rw     = rw;
    cpu_addr   = addr;
    cpu_dout   = dout;
    host_req   = hreq;
    host_we    = hwe;
    host_addr  = haddr;
    host_wdata = hwdata;
    @(negedge cpu_clk);
    if (prev_rd) checkOutput("cpu_rdata", ram_dout, prev_rd_exp);
    pend  = (cyc >= t_accept) && !m_granted;
    grant = pend && (!cs || (rw && n_traffic >= MAX_WAIT));
    blk   = is_blocked(cs, rw, addr);
    if (cyc == t_ack && !m_we) exp_rdata = m_rd_cap;
    exp_busy = (cyc >= t_accept) && (cyc < t_ack);
    exp_rdy  = !(grant && cs);
    exp_cs   = grant || (cs && !blk);
    checkOutput("host_ack", host_ack, cyc == t_ack);
    checkOutput("host_busy", host_busy, exp_busy);
    checkOutput("host_rdata", host_rdata, exp_rdata);
    checkOutput("cpu_rdy", cpu_rdy, exp_rdy);
    checkOutput("prot_viol", prot_viol, prev_blocked);
    checkOutput("ram_cs", ram_cs, exp_cs);
    if (grant) begin
      checkOutput("grant_rw", ram_rw, !m_we);
      checkOutput("grant_addr", ram_addr, m_addr);
      if (m_we) checkOutput("grant_din", ram_din, m_wdata);
    end else if (exp_cs) begin
      checkOutput("cpu_pass_rw", ram_rw, rw);
      checkOutput("cpu_pass_addr", ram_addr, addr);
      if (!rw) checkOutput("cpu_pass_din", ram_din, dout);
    end
    prev_rd     = cs && rw && exp_rdy;
    prev_rd_exp = shadow[addr];
    if (grant) begin
      m_granted = 1'b1;
      t_ack     = cyc + 2;
      if (m_we) shadow[m_addr] = m_wdata;
      else      m_rd_cap       = shadow[m_addr];
    end else if (pend && cs) begin
      n_traffic++;
    end
    if (!grant && cs && !rw && !blk) shadow[addr] = dout;
    prev_blocked = blk;
    last_exp_rdy = exp_rdy;
    if (hreq && m_granted && cyc > t_ack) begin
      t_accept  = cyc + 1;
      t_ack     = NEVER;
      m_granted = 1'b0;
      n_traffic = 0;
      m_we      = hwe;
      m_addr    = haddr;
      m_wdata   = hwdata;
    end
  endtask

  task automatic cpuCycle(input bit cs, input bit rw, input logic [AW-1:0] addr, input logic [DW-1:0] dout);
    applyStimulus(cs, rw, addr, dout, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [DW-1:0] v;
    logic [AW-1:0] a;
    logic [AW-1:0] ha;
    bit            rcs, rrw;
    logic [DW-1:0] rd;
    int            stalls, stall_idx, acks;

    reset      = 1'b1;
    cpu_ram_cs = 1'b1;
    cpu_rw     = 1'b1;
    cpu_addr   = '0;
    cpu_dout   = '0;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    for (int i = 0; i < 32768; i++) begin
      v = DW'($urandom);
      mem[i]   <= v;
      shadow[i] = v;
    end
    repeat (3) @(posedge cpu_clk);
    @(negedge cpu_clk);
    checkOutput("rst_cpu_rdy", cpu_rdy, 1'b1);
    checkOutput("rst_host_busy", host_busy, 1'b0);
    checkOutput("rst_host_ack", host_ack, 1'b0);
    checkOutput("rst_host_rdata", host_rdata, 8'h00);
    checkOutput("rst_prot_viol", prot_viol, 1'b0);
    checkOutput("rst_ram_cs", ram_cs, 1'b0);
    cpu_ram_cs = 1'b0;
    reset      = 1'b0;
    $display("[TB] reset released");

    // Host write into an idle RAM
    applyStimulus(1'b0, 1'b1, '0, '0, 1'b1, 1'b1, 15'h0123, 8'hA5);
    repeat (4) cpuCycle(1'b0, 1'b1, '0, '0);
    checkOutput("t1_ram_word", mem[15'h0123], 8'hA5);

    // Host read back of the same word
    applyStimulus(1'b0, 1'b1, '0, '0, 1'b1, 1'b0, 15'h0123, 8'h00);
    repeat (3) cpuCycle(1'b0, 1'b1, '0, '0);
    checkOutput("t2_ack", host_ack, 1'b1);
    checkOutput("t2_rdata", host_rdata, 8'hA5);
    cpuCycle(1'b0, 1'b1, '0, '0);
    checkOutput("t2_busy_after", host_busy, 1'b0);
    checkOutput("t2_rdata_held", host_rdata, 8'hA5);
    repeat (2) cpuCycle(1'b0, 1'b1, '0, '0);

    // CPU reads every cycle: host must steal exactly one cycle after MAX_WAIT deferrals
    $display("[TB] continuous CPU reads with pending host read");
    a  = pick_addr();
    ha = pick_addr();
    applyStimulus(1'b1, 1'b1, a, '0, 1'b1, 1'b0, ha, '0);
    stalls    = 0;
    stall_idx = -1;
    for (int i = 0; i < MAX_WAIT + 6; i++) begin
      if (last_exp_rdy) a = pick_addr();
      cpuCycle(1'b1, 1'b1, a, '0);
      if (cpu_rdy !== 1'b1) begin
        stalls++;
        stall_idx = i;
      end
    end
    checkOutput("t3_stall_count", stalls, 1);
    checkOutput("t3_stall_cycle", stall_idx, MAX_WAIT);

    // Saturated wait while the CPU writes: no steal until the next CPU read
    $display("[TB] CPU writes with saturated wait");
    applyStimulus(1'b1, 1'b0, 15'h2000, DW'($urandom), 1'b1, 1'b0, pick_addr(), '0);
    stalls = 0;
    for (int i = 0; i < MAX_WAIT + 3; i++) begin
      cpuCycle(1'b1, 1'b0, AW'(15'h2001 + i), DW'($urandom));
      if (cpu_rdy !== 1'b1) stalls++;
    end
    checkOutput("t4_no_steal_on_write", stalls, 0);
    cpuCycle(1'b1, 1'b1, 15'h2001, '0);
    checkOutput("t4_steal_on_read", cpu_rdy, 1'b0);
    cpuCycle(1'b1, 1'b1, 15'h2001, '0);
    checkOutput("t4_reread_ready", cpu_rdy, 1'b1);
    repeat (3) cpuCycle(1'b0, 1'b1, '0, '0);
    for (int i = 0; i < MAX_WAIT + 4; i++) cpuCycle(1'b1, 1'b1, AW'(15'h2000 + i), '0);

    // Request held high across acks: one transaction every 4 cycles
    repeat (2) cpuCycle(1'b0, 1'b1, '0, '0);
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, '0, '0, 1'b1, 1'b0, AW'(15'h0120 + i), '0);
      if (host_ack === 1'b1) acks++;
    end
    checkOutput("t7_ack_count", acks, 3);
    repeat (4) cpuCycle(1'b0, 1'b1, '0, '0);

`ifdef AIM65_ARB_WRPROT_EN
    // Write protection
    $display("[TB] write protection");
    v = shadow[15'h7000];
    cpuCycle(1'b1, 1'b0, 15'h7000, 8'h55);
    cpuCycle(1'b0, 1'b1, '0, '0);
    checkOutput("t6_viol_pulse", prot_viol, 1'b1);
    cpuCycle(1'b1, 1'b1, 15'h7000, '0);
    checkOutput("t6_viol_single", prot_viol, 1'b0);
    cpuCycle(1'b0, 1'b1, '0, '0);
    checkOutput("t6_word_kept", mem[15'h7000], v);
    cpuCycle(1'b1, 1'b0, 15'h6FFF, 8'h66);
    cpuCycle(1'b1, 1'b1, 15'h6FFF, '0);
    cpuCycle(1'b0, 1'b1, '0, '0);
    checkOutput("t6_below_base", mem[15'h6FFF], 8'h66);
    applyStimulus(1'b0, 1'b1, '0, '0, 1'b1, 1'b1, 15'h7000, 8'h3C);
    repeat (4) cpuCycle(1'b0, 1'b1, '0, '0);
    checkOutput("t6_host_write", mem[15'h7000], 8'h3C);
    cpuCycle(1'b1, 1'b1, 15'h7000, '0);
    cpuCycle(1'b0, 1'b1, '0, '0);
`endif

    // Random CPU and host traffic against the timeline model
    $display("[TB] random traffic");
    rcs = 1'b0;
    rrw = 1'b1;
    a   = '0;
    rd  = '0;
    for (int i = 0; i < 3000; i++) begin
      if (last_exp_rdy) begin
        rcs = ($urandom_range(0, 99) < 85);
        rrw = 1'($urandom_range(0, 1));
        a   = pick_addr();
        rd  = DW'($urandom);
      end
      applyStimulus(rcs, rrw, a, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    pick_addr(), DW'($urandom));
    end
    repeat (25) cpuCycle(1'b0, 1'b1, '0, '0);

    // Reset while the CPU is stalled by a steal
    $display("[TB] reset during a stolen cycle");
    a = 15'h1234;
    applyStimulus(1'b1, 1'b1, a, '0, 1'b1, 1'b0, pick_addr(), '0);
    for (int i = 0; i <= MAX_WAIT; i++) cpuCycle(1'b1, 1'b1, a, '0);
    checkOutput("t5_stalled", cpu_rdy, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t5_rst_cpu_rdy", cpu_rdy, 1'b1);
    checkOutput("t5_rst_busy", host_busy, 1'b0);
    checkOutput("t5_rst_ram_cs", ram_cs, 1'b0);
    @(posedge cpu_clk);
    #3;
    cpu_ram_cs = 1'b0;
    host_req   = 1'b0;
    reset      = 1'b0;
    model_reset();
    acks = 0;
    repeat (6) begin
      cpuCycle(1'b1, 1'b1, a, '0);
      if (host_ack === 1'b1) acks++;
    end
    checkOutput("t5_no_ack", acks, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
